// File: rtl/flp_batch_reverse.sv
// flp_batch_reverse: ping-pong batch buffer that hands the backward recursion
// each completed batch of complex floats in reverse time order. Each valid
// input writes one sample into the fill bank. Once a full batch is stored,
// that same valid input also reads one sample, in reverse order, from the
// other bank. Float bits pass through untouched.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   fill   | no complete batch stored yet; writes only, out_valid stays 0
//   stream | every valid write is paired with one reversed read
module flp_batch_reverse #(
    parameter int depth  = 64,
    parameter int f_exp  = 8,
    parameter int f_mant = 23
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [2*(1+f_exp+f_mant)-1:0]     in,
    input  logic                              in_valid,
    output logic [2*(1+f_exp+f_mant)-1:0]     out,
    output logic                              out_valid,
    output logic                              out_first,
    output logic                              out_last
);

    localparam int aw = $clog2(depth);

    typedef struct packed {
        logic              sign;
        logic [f_exp-1:0]  exp;
        logic [f_mant-1:0] mant;
    } float_t;

    typedef struct packed {
        float_t r;
        float_t i;
    } complex_t;

    typedef enum logic {
        fill,
        stream
    } state_t;

    // Both banks live in one array addressed by {bank, index}.
    complex_t mem [2*depth];

    state_t          state;
    logic [aw-1:0]   wcnt;
    logic            wbank;

    // Storage write into the fill bank. The banks are never cleared, because
    // an entry is always rewritten before it is read. A sample that arrives
    // together with rst is dropped.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            mem[{wbank, wcnt}] <= complex_t'(in);
        end
    end

    // Control FSM and registered reversed read. The read index depth-1-wcnt
    // equals ~wcnt because depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= fill;
            wcnt      <= '0;
            wbank     <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (in_valid) begin
            if (state == stream) begin
                out       <= mem[{~wbank, ~wcnt}];
                out_valid <= 1'b1;
                out_first <= (wcnt == '0);
                out_last  <= (wcnt == '1);
            end else begin
                out_valid <= 1'b0;
                out_first <= 1'b0;
                out_last  <= 1'b0;
            end
            wcnt <= wcnt + aw'(1);
            if (wcnt == '1) begin
                wbank <= ~wbank;
                state <= stream;
            end
        end else begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flp_batch_reverse.sv
// Directed bench for flp_batch_reverse. A depth-4 instance covers reset,
// FILL/STREAM ordering, bubbles and reset mid-stream. A depth-2 instance
// covers bit-exact pass-through of special float values.
module tb_flp_batch_reverse;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // depth = 4 instance
    logic        rst4 = 1'b1;
    logic [63:0] in4 = '0;
    logic        v4 = 1'b0;
    logic [63:0] out4;
    logic        ov4, of4, ol4;

    flp_batch_reverse #(.depth(4), .f_exp(8), .f_mant(23)) u4 (
        .clk(clk), .rst(rst4), .in(in4), .in_valid(v4),
        .out(out4), .out_valid(ov4), .out_first(of4), .out_last(ol4)
    );

    // depth = 2 instance
    logic        rst2 = 1'b1;
    logic [63:0] in2 = '0;
    logic        v2 = 1'b0;
    logic [63:0] out2;
    logic        ov2, of2, ol2;

    flp_batch_reverse #(.depth(2), .f_exp(8), .f_mant(23)) u2 (
        .clk(clk), .rst(rst2), .in(in2), .in_valid(v2),
        .out(out2), .out_valid(ov2), .out_first(of2), .out_last(ol2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model for the depth-4 instance: history of accepted samples
    // since the last reset, plus the value out is expected to hold.
    logic [63:0] hist [32];
    int          cnt = 0;
    logic [63:0] exp_out = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] fbits(input int n);
        case (n)
            1:  return 32'h3F800000;
            2:  return 32'h40000000;
            3:  return 32'h40400000;
            4:  return 32'h40800000;
            5:  return 32'h40A00000;
            6:  return 32'h40C00000;
            7:  return 32'h40E00000;
            8:  return 32'h41000000;
            9:  return 32'h41100000;
            10: return 32'h41200000;
            11: return 32'h41300000;
            12: return 32'h41400000;
            13: return 32'h41500000;
            14: return 32'h41600000;
            15: return 32'h41700000;
            16: return 32'h41800000;
            17: return 32'h41880000;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [63:0] cplx(input int n);
        logic [31:0] r;
        r = fbits(n);
        return {r, r ^ 32'h80000000};
    endfunction

    // One clock on the depth-4 instance, then check against the model.
    task automatic send4(input string tag, input bit valid, input int n);
        int k, b, p;
        logic [63:0] e;
        v4  = valid;
        in4 = cplx(n);
        if (valid) begin
            hist[cnt] = cplx(n);
            cnt++;
        end
        @(posedge clk);
        #1;
        if (valid && cnt > 4) begin
            k = cnt - 1;
            b = k / 4;
            p = k % 4;
            e = hist[(b - 1) * 4 + (3 - p)];
            exp_out = e;
            chk({tag, ".out"},   out4, e);
            chk({tag, ".valid"}, {63'd0, ov4}, 64'd1);
            chk({tag, ".first"}, {63'd0, of4}, {63'd0, p == 0});
            chk({tag, ".last"},  {63'd0, ol4}, {63'd0, p == 3});
        end else begin
            chk({tag, ".hold"},  out4, exp_out);
            chk({tag, ".valid"}, {63'd0, ov4}, 64'd0);
            chk({tag, ".first"}, {63'd0, of4}, 64'd0);
            chk({tag, ".last"},  {63'd0, ol4}, 64'd0);
        end
    endtask

    // Reset cycle on the depth-4 instance, optionally with a colliding sample.
    task automatic reset4(input string tag, input bit valid, input int n);
        rst4 = 1'b1;
        v4   = valid;
        in4  = cplx(n);
        @(posedge clk);
        #1;
        cnt = 0;
        exp_out = '0;
        chk({tag, ".out"},   out4, 64'd0);
        chk({tag, ".valid"}, {63'd0, ov4}, 64'd0);
        chk({tag, ".first"}, {63'd0, of4}, 64'd0);
        chk({tag, ".last"},  {63'd0, ol4}, 64'd0);
        rst4 = 1'b0;
        v4   = 1'b0;
    endtask

    task automatic send2(input bit valid, input logic [63:0] d);
        v2  = valid;
        in2 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held 3 cycles with in_valid=1 and in=9.0: nothing stored or output.
        for (int c = 0; c < 3; c++) reset4("rst_hold", 1'b1, 9);

        // FILL then STREAM with continuous valid: 1..8 out as 4,3,2,1 then 8,7,6,5.
        for (int n = 1; n <= 12; n++) send4("cont", 1'b1, n);

        // Bubbles: valid toggling 1,0,1,0 with the same stream.
        reset4("rst_b", 1'b0, 0);
        for (int n = 1; n <= 12; n++) begin
            send4("bub_v", 1'b1, n);
            send4("bub_g", 1'b0, 0);
        end

        // Reset mid-stream colliding with a 9.0 sample, then 10..17 out as 13,12,11,10.
        reset4("rst_c", 1'b0, 0);
        for (int n = 1; n <= 6; n++) send4("pre", 1'b1, n);
        reset4("rst_mid", 1'b1, 9);
        for (int n = 10; n <= 17; n++) send4("post", 1'b1, n);
        send4("tail", 1'b0, 0);

        // Bit-exact pass-through on depth 2.
        rst2 = 1'b1;
        send2(1'b1, 64'h4110000041100000);
        send2(1'b0, '0);
        chk("d2.rst_out", out2, 64'd0);
        chk("d2.rst_valid", {63'd0, ov2}, 64'd0);
        rst2 = 1'b0;
        send2(1'b1, 64'h7F8000007FC00001);
        chk("d2.fill0_valid", {63'd0, ov2}, 64'd0);
        send2(1'b1, 64'h8000000000000001);
        chk("d2.fill1_valid", {63'd0, ov2}, 64'd0);
        send2(1'b1, cplx(1));
        chk("d2.o0", out2, 64'h8000000000000001);
        chk("d2.o0_valid", {63'd0, ov2}, 64'd1);
        chk("d2.o0_first", {63'd0, of2}, 64'd1);
        chk("d2.o0_last", {63'd0, ol2}, 64'd0);
        send2(1'b1, cplx(2));
        chk("d2.o1", out2, 64'h7F8000007FC00001);
        chk("d2.o1_first", {63'd0, of2}, 64'd0);
        chk("d2.o1_last", {63'd0, ol2}, 64'd1);
        send2(1'b0, '0);
        chk("d2.idle_valid", {63'd0, ov2}, 64'd0);
        chk("d2.idle_hold", out2, 64'h7F8000007FC00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
